// File: rtl/seq_booth_mul.sv
// -----------------------------------------------------------------------------
// seq_booth_mul
//
// Iterative radix-4 Booth multiplier with valid/ready handshakes on the operand
// and result sides. One Booth digit is retired per clock, so a product takes
// N = WIDTH/2 + 1 cycles after acceptance. The operation mode (signed or
// unsigned) is captured together with the operands.
//
// Optional build macro:
//   ZERO_SKIP_EN  when defined, an operation with A==0 or B==0 bypasses the
//                 iteration phase and presents Result=0 one cycle after accept.
//
// Parameters:
//   WIDTH        operand width in bits (even, >= 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operands/mode presented
//   in_ready     block can accept operands (IDLE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned; sampled at accept
//   A            multiplicand
//   B            multiplier
//   out_valid    Result valid (DONE)
//   out_ready    consumer accepts Result
//   Result       2*WIDTH-bit product, held until the next product completes
//   busy         high while an operation is in CALC or DONE
// -----------------------------------------------------------------------------
module seq_booth_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 busy
);

   localparam int N  = WIDTH / 2 + 1;       // Booth digits over WIDTH+2 bits
   localparam int CW = $clog2(N + 1);       // iteration counter width
   localparam int AW = 2 * WIDTH + 4;       // accumulator width

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("seq_booth_mul: WIDTH must be even and >= 4");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     acc;        // running sum of partial products
   logic [AW-1:0]     m_sh;       // multiplicand, pre-shifted by 2i
   logic [WIDTH+1:0]  b_sh;       // multiplier, consumed two bits per cycle
   logic              b_prev;     // B[2i-1] of the current digit
   logic [CW-1:0]     cnt;
   logic [2*WIDTH-1:0] result_q;

   logic [AW-1:0]     pp;
   logic [AW-1:0]     acc_next;
   logic              last_iter;
   logic              ext_a, ext_b;
   logic              zero_op;

   // Operand extension bits: the sign bit in signed mode, zero otherwise.
   // A is extended all the way to the accumulator width so that it can be
   // shifted left in place instead of being shifted by a variable amount.
   assign ext_a = signed_mode & A[WIDTH-1];
   assign ext_b = signed_mode & B[WIDTH-1];

`ifdef ZERO_SKIP_EN
   assign zero_op = (A == '0) || (B == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign last_iter = (cnt == CW'(N - 1));

   // Booth recoding of the triplet {B[2i+1], B[2i], B[2i-1]}.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // through the case leaves it unassigned and infers a latch.
      pp = '0;
      unique case ({b_sh[1], b_sh[0], b_prev})
         3'b001, 3'b010: pp = m_sh;                 // +1
         3'b011:         pp = m_sh << 1;            // +2
         3'b100:         pp = -(m_sh << 1);         // -2
         3'b101, 3'b110: pp = -m_sh;                // -1
         default:        pp = '0;                   // 000, 111
      endcase
   end

   assign acc_next = acc + pp;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = zero_op ? DONE : CALC;
         CALC:    if (last_iter) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // NOTE: all clocked state uses non-blocking assignments so that every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Datapath. The operand and accumulator registers are cleared on reset
   // as well, so an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         m_sh     <= '0;
         b_sh     <= '0;
         b_prev   <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  m_sh   <= {{(WIDTH + 4){ext_a}}, A};
                  b_sh   <= {{2{ext_b}}, B};
                  b_prev <= 1'b0;
                  acc    <= '0;
                  cnt    <= '0;
                  if (zero_op) result_q <= '0;
               end
            end
            CALC: begin
               acc    <= acc_next;
               m_sh   <= m_sh << 2;
               b_sh   <= b_sh >> 2;
               b_prev <= b_sh[1];
               cnt    <= cnt + 1'b1;
               // The final digit's partial product is folded in on the same
               // edge that publishes the result.
               if (last_iter) result_q <= acc_next[2*WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign Result    = result_q;

endmodule
